// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

   localparam int WORD_W = 32;

   // Fetch sequencer states; ST_HALT is only reachable with FETCH_ALIGN_CHECK_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

   // Decoder jump codes; code 3 behaves like JUMP_SEQ
   localparam logic [1:0] JUMP_J   = 2'd0;
   localparam logic [1:0] JUMP_SEQ = 2'd1;
   localparam logic [1:0] JUMP_JR  = 2'd2;

   // Sequential successor of a word address, modulo 2^32
   function automatic logic [WORD_W-1:0] pc_inc4(input logic [WORD_W-1:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC selection (jr, j/jal, branch, sequential)
module next_pc_calc
   import fetch_pkg::*;
(
   input  logic [WORD_W-1:0] pc,
   input  logic [25:0]       target,
   input  logic [1:0]        jump,
   input  logic              branch_taken,
   input  logic [WORD_W-1:0] branch_offset,
   input  logic [WORD_W-1:0] jr_addr,
   output logic [WORD_W-1:0] pc_plus4,
   output logic [WORD_W-1:0] next_pc
);

   // Priority: jr, then absolute jump, then taken branch, else fall through
   always_comb begin
      pc_plus4 = pc_inc4(pc);
      next_pc  = pc_plus4;
      case (jump)
         JUMP_JR: next_pc = jr_addr;
         JUMP_J:  next_pc = {pc_plus4[31:28], target, 2'b00};
         JUMP_SEQ: begin
            if (branch_taken) next_pc = pc_plus4 + (branch_offset << 2);
         end
         default: begin
            if (branch_taken) next_pc = pc_plus4 + (branch_offset << 2);
         end
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer; optional FETCH_ALIGN_CHECK_EN adds misalign halt
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC    = 32'h0000_0000,
   parameter int                ACK_TIMEOUT = 16
)(
   input  logic              clk_i,
   input  logic              rst_i,
   output logic              imem_req_o,
   output logic [WORD_W-1:0] imem_addr_o,
   input  logic              imem_ack_i,
   input  logic [WORD_W-1:0] imem_data_i,
   output logic [WORD_W-1:0] instr_o,
   output logic              instr_valid_o,
   input  logic              instr_ready_i,
   output logic [WORD_W-1:0] pc_o,
   output logic [WORD_W-1:0] pc_plus4_o,
   input  logic [1:0]        jump_i,
   input  logic              branch_taken_i,
   input  logic [WORD_W-1:0] branch_offset_i,
   input  logic [WORD_W-1:0] jr_addr_i,
   output logic              timeout_o,
   output logic [WORD_W-1:0] fetch_count_o
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic              misalign_o
`endif
);

   localparam logic [1:0] IDLE  = ST_IDLE;
   localparam logic [1:0] FETCH = ST_FETCH;
   localparam logic [1:0] HOLD  = ST_HOLD;
`ifdef FETCH_ALIGN_CHECK_EN
   localparam logic [1:0] HALT  = ST_HALT;
`endif

   localparam int               CNT_W     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   logic [1:0]        state;
   logic [WORD_W-1:0] pc;
   logic [WORD_W-1:0] pc_plus4;
   logic [WORD_W-1:0] next_raw;
   logic [WORD_W-1:0] next_pc;
   logic [CNT_W-1:0]  wait_cnt;
   logic              fetching;
   logic              ack_hit;
   logic              consume;
   logic              wait_expired;
   logic              load_pc;

   assign fetching     = (state == FETCH);
   assign ack_hit      = fetching & imem_ack_i;
   assign consume      = (state == HOLD) & instr_ready_i;
   assign wait_expired = fetching & ~imem_ack_i & (wait_cnt == WAIT_LAST);

   assign imem_req_o    = fetching;
   assign imem_addr_o   = pc;
   assign instr_valid_o = (state == HOLD);
   assign pc_o          = pc;
   assign pc_plus4_o    = pc_plus4;
   assign timeout_o     = wait_expired;

   next_pc_calc u_next_pc_calc (
      .pc            (pc),
      .target        (instr_o[25:0]),
      .jump          (jump_i),
      .branch_taken  (branch_taken_i),
      .branch_offset (branch_offset_i),
      .jr_addr       (jr_addr_i),
      .pc_plus4      (pc_plus4),
      .next_pc       (next_raw)
   );

`ifdef FETCH_ALIGN_CHECK_EN
   logic misaligned;
   assign misaligned = |next_raw[1:0];
   assign next_pc    = next_raw;
   assign load_pc    = consume & ~misaligned;
   assign misalign_o = (state == HALT);
`else
   logic misaligned;
   assign misaligned = 1'b0;
   assign next_pc    = next_raw & 32'hFFFF_FFFC;
   assign load_pc    = consume;
`endif

   // Sequencer: IDLE -> FETCH -> HOLD -> FETCH ..., HALT on misaligned target
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:  state <= FETCH;
            FETCH: if (imem_ack_i) state <= HOLD;
            HOLD: begin
               if (instr_ready_i) state <= misaligned ? ST_HALT : FETCH;
            end
            default: state <= state;
         endcase
      end
   end

   // Program counter advances only when the decoder consumes the instruction
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)       pc <= RESET_PC;
      else if (load_pc) pc <= next_pc;
   end

   // Instruction register captures the memory word on an accepted ack
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)       instr_o <= '0;
      else if (ack_hit) instr_o <= imem_data_i;
   end

   // Ack-wait counter: runs in FETCH, clears on ack, on expiry, or outside FETCH
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                                       wait_cnt <= '0;
      else if (!fetching || imem_ack_i || wait_expired) wait_cnt <= '0;
      else                                              wait_cnt <= wait_cnt + 1'b1;
   end

   // Completed decoder handshakes, wrapping at 2^32
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)       fetch_count_o <= '0;
      else if (consume) fetch_count_o <= fetch_count_o + 32'd1;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit (honours FETCH_ALIGN_CHECK_EN)
module tb_fetch_unit;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i = 1'b0;
   logic [31:0] imem_data_i = '0;
   logic [31:0] instr_o;
   logic        instr_valid_o;
   logic        instr_ready_i = 1'b0;
   logic [31:0] pc_o;
   logic [31:0] pc_plus4_o;
   logic [1:0]  jump_i = 2'd1;
   logic        branch_taken_i = 1'b0;
   logic [31:0] branch_offset_i = '0;
   logic [31:0] jr_addr_i = '0;
   logic        timeout_o;
   logic [31:0] fetch_count_o;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        misalign_o;
`endif

   fetch_unit #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(TMO)) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .imem_req_o      (imem_req_o),
      .imem_addr_o     (imem_addr_o),
      .imem_ack_i      (imem_ack_i),
      .imem_data_i     (imem_data_i),
      .instr_o         (instr_o),
      .instr_valid_o   (instr_valid_o),
      .instr_ready_i   (instr_ready_i),
      .pc_o            (pc_o),
      .pc_plus4_o      (pc_plus4_o),
      .jump_i          (jump_i),
      .branch_taken_i  (branch_taken_i),
      .branch_offset_i (branch_offset_i),
      .jr_addr_i       (jr_addr_i),
      .timeout_o       (timeout_o),
      .fetch_count_o   (fetch_count_o)
`ifdef FETCH_ALIGN_CHECK_EN
      ,
      .misalign_o      (misalign_o)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_pc = '0;
   logic [31:0] m_count = '0;
   int          first_req_cyc = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] instr,
                                              input logic [1:0] jmp, input logic bt,
                                              input logic [31:0] off, input logic [31:0] jra);
      logic [31:0] p4;
      logic [31:0] n;
      p4 = pc + 32'd4;
      if (jmp == 2'd2)      n = jra;
      else if (jmp == 2'd0) n = {p4[31:28], instr[25:0], 2'b00};
      else if (bt)          n = p4 + {off[29:0], 2'b00};
      else                  n = p4;
      return {n[31:2], 2'b00};
   endfunction

   task automatic scramble_ctrl();
      jump_i          = 2'($urandom);
      branch_taken_i  = 1'($urandom);
      branch_offset_i = $urandom;
      jr_addr_i       = $urandom;
   endtask

   task automatic do_reset();
      rst_i = 1'b0;
      imem_ack_i = 1'b0;
      instr_ready_i = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_valid", instr_valid_o, 1'b0);
      check("rst_req",   imem_req_o,    1'b0);
      check("rst_instr", instr_o,       32'h0);
      check("rst_pc",    pc_o,          32'h0);
      check("rst_count", fetch_count_o, 32'h0);
      check("rst_tmo",   timeout_o,     1'b0);
      rst_i = 1'b1;
      m_pc = '0;
      m_count = '0;
      sb.delete();
   endtask

   task automatic fetch_one(input logic [31:0] data, input int ack_wait, input int rdy_wait,
                            input logic [1:0] jmp, input logic bt,
                            input logic [31:0] off, input logic [31:0] jra);
      int   n;
      exp_t e;
      n = 0;
      while (!imem_req_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req", imem_req_o, 1'b1);
      first_req_cyc = cyc;
      check("addr", imem_addr_o, m_pc);
      for (int k = 1; k <= ack_wait; k++) begin
         check("timeout", timeout_o, 32'((k % TMO) == 0));
         check("addr_hold", imem_addr_o, m_pc);
         @(negedge clk);
      end
      imem_ack_i  = 1'b1;
      imem_data_i = data;
      sb.push_back('{m_pc, data});
      @(negedge clk);
      imem_ack_i  = 1'b0;
      imem_data_i = $urandom;
      n = 0;
      while (!instr_valid_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("valid", instr_valid_o, 1'b1);
      for (int k = 0; k < rdy_wait; k++) begin
         scramble_ctrl();
         imem_ack_i  = 1'b1;
         imem_data_i = ~data;
         @(negedge clk);
         imem_ack_i = 1'b0;
         check("hold_instr", instr_o, data);
         check("hold_req", imem_req_o, 1'b0);
      end
      if (sb.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check("instr", instr_o,    e.instr);
         check("pc",    pc_o,       e.pc);
         check("pc4",   pc_plus4_o, e.pc + 32'd4);
         instr_ready_i   = 1'b1;
         jump_i          = jmp;
         branch_taken_i  = bt;
         branch_offset_i = off;
         jr_addr_i       = jra;
         m_pc    = model_next(e.pc, e.instr, jmp, bt, off, jra);
         m_count = m_count + 32'd1;
      end
      @(negedge clk);
      instr_ready_i = 1'b0;
      scramble_ctrl();
      check("count", fetch_count_o, m_count);
   endtask

   initial begin
      int start_cyc;
      do_reset();

      fetch_one(32'h1111_0001, 0, 0, 2'd1, 1'b0, 32'h0, 32'h0);
      start_cyc = first_req_cyc;
      fetch_one(32'h1111_0002, 0, 0, 2'd1, 1'b0, 32'h0, 32'h0);
      fetch_one(32'h1111_0003, 0, 0, 2'd1, 1'b0, 32'h0, 32'h0);
      check("throughput", 32'(cyc - start_cyc), 32'd6);
      check("count3", fetch_count_o, 32'd3);

      fetch_one(32'h2222_0000, 0, 0, 2'd2, 1'b0, 32'h0, 32'h0000_0100);
      fetch_one(32'h0800_0010, 0, 0, 2'd0, 1'b0, 32'h0, 32'h0);
      check("jump_tgt", m_pc, 32'h0000_0040);
      fetch_one(32'h3333_0000, 1, 0, 2'd2, 1'b0, 32'h0, 32'h0000_0200);
      fetch_one(32'h4444_0000, 0, 1, 2'd1, 1'b1, 32'hFFFF_FFFE, 32'h0);
      fetch_one(32'h5555_0000, 0, 0, 2'd2, 1'b0, 32'h0, 32'h0000_0200);
      fetch_one(32'h6666_0000, 0, 0, 2'd2, 1'b1, 32'hFFFF_FFFE, 32'h0000_0300);
      fetch_one(32'h7777_0000, 9, 3, 2'd3, 1'b0, 32'h0000_0040, 32'h0);
      fetch_one(32'h8888_0000, 0, 0, 2'd2, 1'b0, 32'h0, 32'hFFFF_FFFC);
      fetch_one(32'h9999_0000, 0, 0, 2'd1, 1'b0, 32'h0, 32'h0);
      fetch_one(32'hAAAA_0000, 0, 0, 2'd2, 1'b0, 32'h0, 32'h7000_0000);
      fetch_one(32'h0BFF_FFFF, 0, 0, 2'd0, 1'b0, 32'h0, 32'h0);
      fetch_one(32'hBBBB_0000, 2, 2, 2'd2, 1'b0, 32'h0, 32'h0000_0102);
`ifdef FETCH_ALIGN_CHECK_EN
      check("misalign",   misalign_o,    1'b1);
      check("halt_req",   imem_req_o,    1'b0);
      check("halt_valid", instr_valid_o, 1'b0);
      repeat (3) @(negedge clk);
      check("halt_stay",  misalign_o,    1'b1);
      do_reset();
`else
      check("align_tgt", m_pc, 32'h0000_0100);
      fetch_one(32'hCCCC_0000, 0, 0, 2'd1, 1'b0, 32'h0, 32'h0);
`endif

      for (int i = 0; i < 8; i++) begin
         fetch_one($urandom, $urandom_range(0, 5), $urandom_range(0, 3),
                   2'($urandom), 1'($urandom), $urandom, $urandom & 32'hFFFF_FFFC);
      end

      if (!imem_req_o) @(negedge clk);
      check("mid_req", imem_req_o, 1'b1);
      imem_ack_i  = 1'b1;
      imem_data_i = 32'hDEAD_BEEF;
      rst_i       = 1'b0;
      #1;
      check("abort_valid", instr_valid_o, 1'b0);
      check("abort_pc",    pc_o,          32'h0);
      check("abort_count", fetch_count_o, 32'h0);
      check("abort_req",   imem_req_o,    1'b0);
      @(negedge clk);
      check("abort_instr", instr_o,       32'h0);
      imem_ack_i = 1'b0;
      rst_i      = 1'b1;
      m_pc = '0;
      m_count = '0;
      sb.delete();
      fetch_one(32'h1234_5678, 0, 0, 2'd1, 1'b0, 32'h0, 32'h0);
      fetch_one(32'h8765_4321, 0, 0, 2'd1, 1'b0, 32'h0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got running expected finished");
      $fatal(1, "watchdog");
   end

endmodule
